// File: rtl/jtkcpu_stack_seq_pkg.sv
// Shared constants for the push/pull stack sequencer: state encoding,
// default wide-register set, postbyte bit positions and a bit-scan helper.
package jtkcpu_stack_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEC,
        ST_WR,
        ST_RD,
        ST_DONE
    } stack_state_t;

    localparam logic [7:0] WIDE_MASK_DEF = 8'hF0;

    localparam int PSH_PC = 7;
    localparam int PSH_US = 6;
    localparam int PSH_Y  = 5;
    localparam int PSH_X  = 4;
    localparam int PSH_DP = 3;
    localparam int PSH_B  = 2;
    localparam int PSH_A  = 1;
    localparam int PSH_CC = 0;

    // Isolates the lowest set bit (two's complement trick); zero in, zero out.
    function automatic logic [7:0] lowest_bit(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/jtkcpu_stack_seq_if.sv
// Bundle between the stack sequencer (bus master) and the register file /
// core control (slave) that launches transfers and serves stack_bit.
interface jtkcpu_stack_seq_if;

    logic       cen;
    logic       psh_go;
    logic       pul_go;
    logic [7:0] mask;
    logic       ussel_in;
    logic [7:0] stack_bit;
    logic [7:0] psh_sel;
    logic       psh_hihalf;
    logic       psh_ussel;
    logic       psh_dec;
    logic       pul_en;
    logic       stack_busy;
    logic       we;
    logic       rd;
    logic       done;

    modport master (
        input  cen, psh_go, pul_go, mask, ussel_in, stack_bit,
        output psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en,
               stack_busy, we, rd, done
    );

    modport slave (
        output cen, psh_go, pul_go, mask, ussel_in, stack_bit,
        input  psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en,
               stack_busy, we, rd, done
    );

endinterface

// File: rtl/jtkcpu_stack_seq.sv
// Byte-serial push/pull sequencer for PSHS/PSHU/PULS/PULU, interrupt entry
// and RTI. The register file picks the register being served via stack_bit.
module jtkcpu_stack_seq
    import jtkcpu_stack_seq_pkg::*;
#(
    parameter logic [7:0] WIDE_MASK = WIDE_MASK_DEF
) (
    input  logic               rst,
    input  logic               clk,
    jtkcpu_stack_seq_if.master bus
);

    stack_state_t state;
    logic [7:0]   psh_sel;
    logic         psh_hihalf;
    logic         psh_ussel;
    logic         pul_en;

    logic         bit_wide;
    logic [7:0]   rem_sel;
    logic [7:0]   pull_first;
    logic [7:0]   pull_next;

    assign bit_wide   = |(bus.stack_bit & WIDE_MASK);
    assign rem_sel    = psh_sel & ~bus.stack_bit;
    assign pull_first = lowest_bit(bus.mask);
    assign pull_next  = lowest_bit(rem_sel);

    // Pushes go DEC->WR per byte, low byte of a wide register first so the
    // high byte lands at the lower address; pulls read that order back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            psh_sel    <= 8'h00;
            psh_hihalf <= 1'b0;
            psh_ussel  <= 1'b0;
            pul_en     <= 1'b0;
        end else if (bus.cen) begin
            case (state)
                ST_IDLE: begin
                    if (bus.psh_go) begin
                        psh_sel    <= bus.mask;
                        psh_ussel  <= bus.ussel_in;
                        psh_hihalf <= 1'b0;
                        state      <= (bus.mask == 8'h00) ? ST_DONE : ST_DEC;
                    end else if (bus.pul_go) begin
                        psh_sel    <= bus.mask;
                        psh_ussel  <= bus.ussel_in;
                        pul_en     <= 1'b1;
                        psh_hihalf <= |(pull_first & WIDE_MASK);
                        state      <= (bus.mask == 8'h00) ? ST_DONE : ST_RD;
                    end
                end
                ST_DEC: state <= ST_WR;
                ST_WR: begin
                    if (bit_wide && !psh_hihalf) begin
                        psh_hihalf <= 1'b1;
                        state      <= ST_DEC;
                    end else begin
                        psh_sel    <= rem_sel;
                        psh_hihalf <= 1'b0;
                        state      <= (rem_sel != 8'h00) ? ST_DEC : ST_DONE;
                    end
                end
                ST_RD: begin
                    if (bit_wide && psh_hihalf) begin
                        psh_hihalf <= 1'b0;
                    end else begin
                        psh_sel    <= rem_sel;
                        psh_hihalf <= |(pull_next & WIDE_MASK);
                        state      <= (rem_sel != 8'h00) ? ST_RD : ST_DONE;
                    end
                end
                ST_DONE: begin
                    pul_en     <= 1'b0;
                    psh_hihalf <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.psh_sel    = psh_sel;
    assign bus.psh_hihalf = psh_hihalf;
    assign bus.psh_ussel  = psh_ussel;
    assign bus.pul_en     = pul_en;
    assign bus.psh_dec    = (state == ST_DEC);
    assign bus.we         = (state == ST_WR);
    assign bus.rd         = (state == ST_RD);
    assign bus.done       = (state == ST_DONE);
    assign bus.stack_busy = (state != ST_IDLE);

endmodule
